quad_decoder: RTL
=================

# quad_decoder

Multi-channel quadrature decoder for the panel's rotary encoders (one per paddle plus spares). Each channel synchronises and debounces the A/B/switch pins, tracks the full Gray-code sequence with a configurable steps-per-detent ratio, and emits one-cycle up/down/press pulses plus a bounded position register. It sits between the board pins and the game logic and replaces ad-hoc first-edge detection with a robust, illegal-transition-aware decoder.

## Interface
- NUM_CH, 2, number of independent encoder channels (≥1)
- SYNC_STAGES, 2, flip-flops in each pin synchroniser (≥2)
- DEB_CYCLES, 1000, consecutive stable cycles required to accept a new pin level (≥1)
- STEPS, 4, legal Gray transitions per detent; one of 1, 2, 4
- POS_W, 8, position register width
- POS_MIN, 0, lower position bound and reset value
- POS_MAX, 255, upper position bound (POS_MIN < POS_MAX < 2^POS_W)
- WRAP, 0, 0 = saturate at bounds, 1 = wrap to the opposite bound
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_a  in  NUM_CH  raw encoder A pins
- in_b  in  NUM_CH  raw encoder B pins
- switch  in  NUM_CH  raw push-switch pins, active-high
- clr  in  NUM_CH  synchronous clear of position, sub-step accumulator and err
- up  out  NUM_CH  one-cycle pulse per detent, A-leads direction
- down  out  NUM_CH  one-cycle pulse per detent, B-leads direction
- button  out  NUM_CH  debounced switch level
- press  out  NUM_CH  one-cycle pulse on debounced switch rising edge
- pos  out  NUM_CH*POS_W  position, channel i at [i*POS_W +: POS_W]
- err  out  NUM_CH  sticky: illegal transition (A and B changed together)

## Operation
- Per pin: SYNC_STAGES synchroniser → debounce filter. Filter holds stable level and counter; counter increments while synced input ≠ stable, resets to 0 when equal; at DEB_CYCLES−1 stable flips and counter clears.
- Channel FSM states: INIT, TRACK.
- INIT: startup counter runs SYNC_STAGES+DEB_CYCLES+1 cycles; then prev ← {a_deb,b_deb}, prev_sw ← sw_deb, enter TRACK. No pulses, pos/err unchanged in INIT.
- TRACK: cur = {a_deb,b_deb}. Forward sequence 00→10→11→01→00 adds +1 to signed 3-bit accumulator acc; reverse adds −1; cur = prev does nothing; both bits changed → err ← 1, acc ← 0, no pulse. prev ← cur every cycle.
- acc reaching +STEPS: up pulse, acc ← 0. Reaching −STEPS: down pulse, acc ← 0. Direction reversal mid-detent simply decrements acc.
- Position: on up, pos+1; at POS_MAX holds (WRAP=0) or becomes POS_MIN (WRAP=1). Mirror for down at POS_MIN. up/down pulses are emitted even when pos saturates.
- press: sw_deb rising edge in TRACK. button = sw_deb in all states.
- clr: pos ← POS_MIN, acc ← 0, err ← 0 the next edge; clr wins over a same-cycle step (that step's pulse still emitted). Does not affect FSM state or filters.
- Channels fully independent; no shared state.

## Timing
- Reset (async assert, sync-free deassert acceptable): up=down=press=err=0, button=0, pos=POS_MIN, acc=0, filters stable=0, counters=0, FSM=INIT.
- Pin edge at cycle 0 → synced at SYNC_STAGES → debounced at SYNC_STAGES+DEB_CYCLES → up/down/press registered, visible at SYNC_STAGES+DEB_CYCLES+1.
- pos updates the same cycle its up/down pulse is high.
- Glitch shorter than DEB_CYCLES cycles on synced input: no output change.
- Reset mid-detent: acc discarded, channel re-enters INIT.

## Structure
- Package quad_pkg: channel state enum (INIT, TRACK), Gray step function (prev,cur → +1/−1/0/illegal), STEPS legality check.
- Sub-module quad_channel (sync, three debounce filters, FSM, acc, pos); top generates NUM_CH instances and packs pos.

## Test plan
- Defaults, DEB_CYCLES=4: after INIT, drive one forward cycle 00→10→11→01→00 with 10-cycle holds → exactly one up pulse, pos 0→1, down never high.
- STEPS=1, four reverse transitions from pos=0, WRAP=0 → four down pulses, pos stays 0; WRAP=1 → pos 255,254,253,252.
- 3-cycle glitch on in_a with DEB_CYCLES=4 → no pulse, pos and acc unchanged.
- Drive 00→11 directly → err=1, no pulse; next forward detent counts from acc=0; clr → err=0, pos=0.
- Half detent forward (+2) then back (−2) → no pulses, pos unchanged.
- NUM_CH=2: ch0 forward detents while ch1 switch pressed → ch0 up only, ch1 press one pulse, button high while held; async reset mid-sequence → all outputs 0, pos=POS_MIN immediately.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder.
//   ch_state_e  : per-channel state (StInit while filters settle, StTrack once decoding)
//   step_e      : classification of one debounced A/B transition
//   gray_step   : classify prev -> cur A/B pair; forward order is 00 -> 10 -> 11 -> 01 -> 00
//   steps_legal : accepted steps-per-detent ratios
package quad_pkg;

   typedef enum logic {
      StInit,
      StTrack
   } ch_state_e;

   typedef enum logic [1:0] {
      StepNone,
      StepFwd,
      StepRev,
      StepIllegal
   } step_e;

   // Arguments are {a, b}.
   function automatic step_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
      step_e s;
      if (prev == cur) begin
         s = StepNone;
      end else if ((prev[1] != cur[1]) && (prev[0] != cur[0])) begin
         s = StepIllegal;
      end else begin
         case ({prev, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: s = StepFwd;
            default:                            s = StepRev;
         endcase
      end
      return s;
   endfunction

   function automatic bit steps_legal(input int unsigned steps);
      return (steps == 1) || (steps == 2) || (steps == 4);
   endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: pin synchronisers, three debounce filters (A, B, switch),
// INIT/TRACK FSM, signed sub-detent accumulator and bounded position register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_a, in_b, switch  raw pins
//   clr                 synchronous clear of pos, acc and err
//   up, down, press     one-cycle registered pulses
//   button              debounced switch level
//   pos                 position, POS_MIN..POS_MAX
//   err                 sticky illegal-transition flag
module quad_channel
   import quad_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 1000,
   parameter int unsigned STEPS       = 4,
   parameter int unsigned POS_W       = 8,
   parameter int unsigned POS_MIN     = 0,
   parameter int unsigned POS_MAX     = 255,
   parameter bit          WRAP        = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             switch,
   input  logic             clr,
   output logic             up,
   output logic             down,
   output logic             button,
   output logic             press,
   output logic [POS_W-1:0] pos,
   output logic             err
);

   localparam int unsigned DebW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
   localparam int unsigned InitLen  = SYNC_STAGES + DEB_CYCLES + 1;
   localparam int unsigned InitW    = $clog2(InitLen);
   localparam logic [InitW-1:0] InitLast = InitW'(InitLen - 1);
   localparam logic [POS_W-1:0] PosMin = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0] PosMax = POS_W'(POS_MAX);
   // acc is 3-bit two's complement; the sum is taken one bit wider so +4 is representable.
   localparam logic [3:0] StepsUp = 4'(STEPS);
   localparam logic [3:0] StepsDn = 4'(16 - STEPS);

   // Pin index: 0 = A, 1 = B, 2 = switch.
   logic [2:0]                  pins;
   logic [2:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [2:0]                  synced;
   logic [2:0][DebW-1:0]        deb_cnt_q, deb_cnt_d;
   logic [2:0]                  deb_q, deb_d;

   ch_state_e        state_q, state_d;
   logic [InitW-1:0] init_cnt_q, init_cnt_d;
   logic [1:0]       prev_q, prev_d;
   logic             prev_sw_q, prev_sw_d;
   logic [2:0]       acc_q, acc_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             err_q, err_d;
   logic             up_q, up_d;
   logic             down_q, down_d;
   logic             press_q, press_d;

   logic [1:0] cur;
   step_e      step;
   logic [3:0] delta;
   logic [3:0] acc_sum;

   assign pins = {switch, in_b, in_a};
   assign cur  = {deb_q[0], deb_q[1]};

   // Synchronisers and debounce filters.
   always_comb begin
      sync_d    = sync_q;
      deb_cnt_d = '0;
      deb_d     = deb_q;
      synced    = '0;
      for (int p = 0; p < 3; p++) begin
         sync_d[p] = {sync_q[p][SYNC_STAGES-2:0], pins[p]};
         synced[p] = sync_q[p][SYNC_STAGES-1];
         if (synced[p] != deb_q[p]) begin
            if (deb_cnt_q[p] == DebLast) begin
               deb_d[p] = ~deb_q[p];
            end else begin
               deb_cnt_d[p] = deb_cnt_q[p] + DebW'(1);
            end
         end
      end
   end

   // Channel FSM, accumulator and position.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      prev_d     = prev_q;
      prev_sw_d  = prev_sw_q;
      acc_d      = acc_q;
      pos_d      = pos_q;
      err_d      = err_q;
      up_d       = 1'b0;
      down_d     = 1'b0;
      press_d    = 1'b0;
      step       = gray_step(prev_q, cur);
      delta      = 4'd0;
      acc_sum    = 4'd0;

      case (state_q)
         StInit: begin
            if (init_cnt_q == InitLast) begin
               init_cnt_d = '0;
               prev_d     = cur;
               prev_sw_d  = deb_q[2];
               state_d    = StTrack;
            end else begin
               init_cnt_d = init_cnt_q + InitW'(1);
            end
         end
         StTrack: begin
            prev_d    = cur;
            prev_sw_d = deb_q[2];
            press_d   = deb_q[2] & ~prev_sw_q;
            if (step == StepFwd) begin
               delta = 4'b0001;
            end else if (step == StepRev) begin
               delta = 4'b1111;
            end
            acc_sum = {acc_q[2], acc_q} + delta;
            if (step == StepIllegal) begin
               err_d = 1'b1;
               acc_d = '0;
            end else if ((step == StepFwd) || (step == StepRev)) begin
               if (acc_sum == StepsUp) begin
                  up_d  = 1'b1;
                  acc_d = '0;
                  if (pos_q == PosMax) begin
                     pos_d = WRAP ? PosMin : PosMax;
                  end else begin
                     pos_d = pos_q + POS_W'(1);
                  end
               end else if (acc_sum == StepsDn) begin
                  down_d = 1'b1;
                  acc_d  = '0;
                  if (pos_q == PosMin) begin
                     pos_d = WRAP ? PosMax : PosMin;
                  end else begin
                     pos_d = pos_q - POS_W'(1);
                  end
               end else begin
                  acc_d = acc_sum[2:0];
               end
            end
         end
         default: state_d = StInit;
      endcase

      // Clear overrides the datapath but leaves the pulse of a coincident detent intact.
      if (clr) begin
         pos_d = PosMin;
         acc_d = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         deb_cnt_q  <= '0;
         deb_q      <= '0;
         state_q    <= StInit;
         init_cnt_q <= '0;
         prev_q     <= '0;
         prev_sw_q  <= 1'b0;
         acc_q      <= '0;
         pos_q      <= PosMin;
         err_q      <= 1'b0;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         deb_cnt_q  <= deb_cnt_d;
         deb_q      <= deb_d;
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         prev_q     <= prev_d;
         prev_sw_q  <= prev_sw_d;
         acc_q      <= acc_d;
         pos_q      <= pos_d;
         err_q      <= err_d;
         up_q       <= up_d;
         down_q     <= down_d;
         press_q    <= press_d;
      end
   end

   assign up     = up_q;
   assign down   = down_q;
   assign press  = press_q;
   assign button = deb_q[2];
   assign pos    = pos_q;
   assign err    = err_q;

endmodule

// File: rtl/quad_decoder.sv
// Multi-channel quadrature decoder: NUM_CH independent quad_channel instances.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_a, in_b, switch      raw encoder pins, one bit per channel
//   clr                     per-channel synchronous clear
//   up, down, press         per-channel one-cycle pulses
//   button                  per-channel debounced switch level
//   pos                     packed positions, channel i at [i*POS_W +: POS_W]
//   err                     per-channel sticky illegal-transition flag
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 1000,
   parameter int unsigned STEPS       = 4,
   parameter int unsigned POS_W       = 8,
   parameter int unsigned POS_MIN     = 0,
   parameter int unsigned POS_MAX     = 255,
   parameter bit          WRAP        = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_a,
   input  logic [NUM_CH-1:0]       in_b,
   input  logic [NUM_CH-1:0]       switch,
   input  logic [NUM_CH-1:0]       clr,
   output logic [NUM_CH-1:0]       up,
   output logic [NUM_CH-1:0]       down,
   output logic [NUM_CH-1:0]       button,
   output logic [NUM_CH-1:0]       press,
   output logic [NUM_CH*POS_W-1:0] pos,
   output logic [NUM_CH-1:0]       err
);

   if (!steps_legal(STEPS)) begin : g_bad_steps
      $error("quad_decoder: STEPS must be 1, 2 or 4");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      quad_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_CYCLES  (DEB_CYCLES),
         .STEPS       (STEPS),
         .POS_W       (POS_W),
         .POS_MIN     (POS_MIN),
         .POS_MAX     (POS_MAX),
         .WRAP        (WRAP)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .in_a   (in_a[i]),
         .in_b   (in_b[i]),
         .switch (switch[i]),
         .clr    (clr[i]),
         .up     (up[i]),
         .down   (down[i]),
         .button (button[i]),
         .press  (press[i]),
         .pos    (pos[i*POS_W +: POS_W]),
         .err    (err[i])
      );
   end

endmodule
